matadd_avmm_master: RTL

// Avalon-MM master driving the memory-mapped matrix add/sub accelerator slave (A at 0..255,
// B at 256..511, GO at 512, results C read back at 0..255). Pulls A then B words from an

---
 rtl/matadd_pkg.sv | 12 +
 rtl/matadd_avmm_master.sv | 116 +++++++++++
 2 files changed

// File: rtl/matadd_pkg.sv
// matadd_pkg: address map, byte-enable codes and FSM states shared by the matrix add/sub master
package matadd_pkg;
  localparam int A_BASE = 0;
  localparam int B_BASE = 256;
  localparam int GO_ADDR = 512;
  localparam logic [7:0] BE_LO = 8'h0F;
  localparam logic [7:0] BE_HI = 8'hF0;
  localparam logic [7:0] BE_ALL = 8'hFF;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_LO, S_WR_HI, S_GO, S_SETTLE, S_RD, S_PUSH, S_FIN
  } state_e;
endpackage

// File: rtl/matadd_avmm_master.sv
// matadd_avmm_master: streams A/B into the accelerator over Avalon-MM, triggers GO, streams C back out
module matadd_avmm_master #(
  parameter int N_WORDS = 256,
  parameter int B_BASE = matadd_pkg::B_BASE,
  parameter int GO_ADDR = matadd_pkg::GO_ADDR,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [9:0]  avm_address,
  output logic [63:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_read,
  output logic [7:0]  avm_byteenable,
  input  logic [63:0] avm_readdata,
  input  logic        avm_waitrequest
);
  import matadd_pkg::*;
  localparam int CW = $clog2(2 * N_WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0] data_q, data_d;
  logic error_q, error_d;
  logic wr, accept, expire;
  logic [9:0] waddr;
  // Bus outputs are pure decodes of registered state so an async reset clears them at once
  always_comb begin
    wr = state_q == S_WR_LO || state_q == S_WR_HI;
    waddr = widx_q < CW'(N_WORDS) ? 10'(A_BASE) + 10'(widx_q) : 10'(B_BASE) + 10'(widx_q - CW'(N_WORDS));
    busy = state_q != S_IDLE && state_q != S_FIN;
    done = state_q == S_FIN;
    error = error_q;
    in_ready = state_q == S_FETCH;
    out_valid = state_q == S_PUSH;
    out_data = data_q;
    avm_write = wr || state_q == S_GO;
    avm_read = state_q == S_RD;
    avm_address = wr ? waddr : state_q == S_GO ? 10'(GO_ADDR) : avm_read ? 10'(ridx_q) : '0;
    avm_writedata = wr ? data_q : '0;
    avm_byteenable = state_q == S_WR_LO ? BE_LO : state_q == S_WR_HI ? BE_HI :
                     (state_q == S_GO || avm_read) ? BE_ALL : '0;
    accept = (avm_write || avm_read) && !avm_waitrequest;
    expire = (avm_write || avm_read) && avm_waitrequest && tmo_q == TW'(TIMEOUT - 1);
  end
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    ridx_d = ridx_q;
    data_d = data_q;
    error_d = error_q;
    tmo_d = ((avm_write || avm_read) && avm_waitrequest) ? tmo_q + 1'b1 : '0;
    if (expire) begin
      state_d = S_FIN;
      error_d = 1'b1;
      tmo_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_FETCH;
          error_d = 1'b0;
          widx_d = '0;
          ridx_d = '0;
        end
        S_FETCH: if (in_valid) begin
          data_d = in_data;
          state_d = S_WR_LO;
        end
        S_WR_LO: if (accept) state_d = S_WR_HI;
        S_WR_HI: if (accept) begin
          widx_d = widx_q + 1'b1;
          state_d = widx_q == CW'(2 * N_WORDS - 1) ? S_GO : S_FETCH;
        end
        S_GO: if (accept) state_d = S_SETTLE;
        S_SETTLE: state_d = S_RD;
        S_RD: if (accept) begin
          data_d = avm_readdata;
          state_d = S_PUSH;
        end
        S_PUSH: if (out_ready) begin
          ridx_d = ridx_q + 1'b1;
          state_d = ridx_q == CW'(N_WORDS - 1) ? S_FIN : S_RD;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      widx_q <= '0;
      ridx_q <= '0;
      tmo_q <= '0;
      data_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      ridx_q <= ridx_d;
      tmo_q <= tmo_d;
      data_q <= data_d;
      error_q <= error_d;
    end
  end
endmodule
